// File: rtl/ctrl_prog_ram.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_prog_ram
// Purpose  : Decides who owns the SAP-1 RAM address mux (loader or MAR) and
//            sequences RAM write strobes during program load.
// Revision : 1.0
// ============================================================================
module ctrl_prog_ram #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 16,
    parameter int WR_PULSE  = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Prog_Mode,
    input  logic              Run_Req,
    input  logic              Ld_Valid,
    input  logic [DATA_W-1:0] Ld_Data,
    input  logic              Ld_Last,
    output logic              Ld_Ready,
    output logic              Mux_Select,
    output logic              Mux_Enable,
    output logic [ADDR_W-1:0] Prog_Addr,
    output logic [DATA_W-1:0] Ram_Data,
    output logic              Ram_WE_n,
    output logic              Cpu_Hold,
    output logic              Prog_Done,
    output logic              Err_Overflow
);

    localparam int CNT_W = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_GUARD      = 3'd1;
    localparam logic [2:0] S_PROG_WAIT  = 3'd2;
    localparam logic [2:0] S_PROG_WRITE = 3'd3;
    localparam logic [2:0] S_PROG_NEXT  = 3'd4;
    localparam logic [2:0] S_RUN        = 3'd5;

    localparam logic [ADDR_W-1:0] c_last_addr  = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [CNT_W-1:0]  c_pulse_last = CNT_W'(WR_PULSE - 1);

    logic [2:0]        r_state, w_state_nxt;
    logic              r_tgt_prog, w_tgt_prog_nxt;
    logic              r_last, w_last_nxt;
    logic [CNT_W-1:0]  r_wr_cnt, w_wr_cnt_nxt;
    logic              r_ld_ready, w_ld_ready_nxt;
    logic              r_mux_sel, w_mux_sel_nxt;
    logic              r_mux_en, w_mux_en_nxt;
    logic [ADDR_W-1:0] r_prog_addr, w_prog_addr_nxt;
    logic [DATA_W-1:0] r_ram_data, w_ram_data_nxt;
    logic              r_we_n, w_we_n_nxt;
    logic              r_cpu_hold, w_cpu_hold_nxt;
    logic              r_done, w_done_nxt;
    logic              r_err, w_err_nxt;
    logic              w_handshake;

    assign w_handshake = (r_state == S_PROG_WAIT) && Ld_Valid && r_ld_ready;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_tgt_prog  <= 1'b0;
            r_last      <= 1'b0;
            r_wr_cnt    <= '0;
            r_ld_ready  <= 1'b0;
            r_mux_sel   <= 1'b0;
            r_mux_en    <= 1'b1;
            r_prog_addr <= '0;
            r_ram_data  <= '0;
            r_we_n      <= 1'b1;
            r_cpu_hold  <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tgt_prog  <= w_tgt_prog_nxt;
            r_last      <= w_last_nxt;
            r_wr_cnt    <= w_wr_cnt_nxt;
            r_ld_ready  <= w_ld_ready_nxt;
            r_mux_sel   <= w_mux_sel_nxt;
            r_mux_en    <= w_mux_en_nxt;
            r_prog_addr <= w_prog_addr_nxt;
            r_ram_data  <= w_ram_data_nxt;
            r_we_n      <= w_we_n_nxt;
            r_cpu_hold  <= w_cpu_hold_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:       if (Prog_Mode || Run_Req) w_state_nxt = S_GUARD;
            S_GUARD:      w_state_nxt = r_tgt_prog ? S_PROG_WAIT : S_RUN;
            S_PROG_WAIT: begin
                if (w_handshake)     w_state_nxt = S_PROG_WRITE;
                else if (!Prog_Mode) w_state_nxt = S_IDLE;
            end
            S_PROG_WRITE: if (r_wr_cnt == c_pulse_last) w_state_nxt = S_PROG_NEXT;
            S_PROG_NEXT: begin
                if (r_last || !Prog_Mode || (r_prog_addr == c_last_addr))
                    w_state_nxt = S_IDLE;
                else
                    w_state_nxt = S_PROG_WAIT;
            end
            S_RUN:        if (Prog_Mode || !Run_Req) w_state_nxt = S_IDLE;
            default:      w_state_nxt = S_IDLE;
        endcase
    end

    // Registered outputs are computed from the state being entered, so every
    // pin settles on the same edge as the state change.
    always_comb begin
        w_tgt_prog_nxt  = r_tgt_prog;
        w_last_nxt      = r_last;
        w_wr_cnt_nxt    = '0;
        w_ld_ready_nxt  = 1'b0;
        w_mux_sel_nxt   = r_mux_sel;
        w_mux_en_nxt    = 1'b1;
        w_prog_addr_nxt = r_prog_addr;
        w_ram_data_nxt  = r_ram_data;
        w_we_n_nxt      = 1'b1;
        w_cpu_hold_nxt  = 1'b1;
        w_done_nxt      = r_done;
        w_err_nxt       = r_err;

        if (r_state == S_IDLE) w_tgt_prog_nxt = Prog_Mode;
        if (r_state == S_GUARD && r_tgt_prog) begin
            w_prog_addr_nxt = '0;
            w_done_nxt      = 1'b0;
            w_err_nxt       = 1'b0;
        end
        if (w_handshake) begin
            w_ram_data_nxt = Ld_Data;
            w_last_nxt     = Ld_Last;
        end
        if (r_state == S_PROG_WRITE && w_state_nxt == S_PROG_WRITE)
            w_wr_cnt_nxt = r_wr_cnt + CNT_W'(1);
        if (r_state == S_PROG_NEXT) begin
            if (r_last || !Prog_Mode) begin
                w_done_nxt = 1'b1;
            end else if (r_prog_addr == c_last_addr) begin
                w_done_nxt = 1'b1;
                w_err_nxt  = 1'b1;
            end else begin
                w_prog_addr_nxt = r_prog_addr + ADDR_W'(1);
            end
        end

        case (w_state_nxt)
            S_GUARD:      w_mux_sel_nxt = !w_tgt_prog_nxt;
            S_PROG_WAIT: begin
                w_mux_en_nxt   = 1'b0;
                w_mux_sel_nxt  = 1'b0;
                w_ld_ready_nxt = 1'b1;
            end
            S_PROG_WRITE: begin
                w_mux_en_nxt  = 1'b0;
                w_mux_sel_nxt = 1'b0;
                w_we_n_nxt    = 1'b0;
            end
            S_PROG_NEXT: begin
                w_mux_en_nxt  = 1'b0;
                w_mux_sel_nxt = 1'b0;
            end
            S_RUN: begin
                w_mux_en_nxt   = 1'b0;
                w_mux_sel_nxt  = 1'b1;
                w_cpu_hold_nxt = 1'b0;
            end
            default: w_mux_en_nxt = 1'b1;
        endcase
    end

    assign Ld_Ready     = r_ld_ready;
    assign Mux_Select   = r_mux_sel;
    assign Mux_Enable   = r_mux_en;
    assign Prog_Addr    = r_prog_addr;
    assign Ram_Data     = r_ram_data;
    assign Ram_WE_n     = r_we_n;
    assign Cpu_Hold     = r_cpu_hold;
    assign Prog_Done    = r_done;
    assign Err_Overflow = r_err;

endmodule
`default_nettype wire
